// File: rtl/h_u_seq_restoring_div8.sv
// rtl/h_u_seq_restoring_div8.sv - sequential restoring divider, 2N-bit by N-bit unsigned
//
// Purpose: divides an unsigned 2N-bit dividend by an unsigned N-bit divisor
// using the restoring algorithm. It finds one quotient bit per RUN cycle, MSB
// first. A divide-by-zero request or a quotient that cannot fit in N bits is
// detected when the operands are accepted. That case spends one RUN cycle and
// then reports the matching flag.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        request; accepted in IDLE or DONE (busy=0)
//   dividend     2N-bit unsigned dividend, captured on accept
//   divisor      N-bit unsigned divisor, captured on accept
//   busy         high while in RUN
//   done         one-cycle pulse; results valid
//   quotient     N-bit quotient (all ones when a flag is set)
//   remainder    N-bit remainder (dividend low half when a flag is set)
//   div_by_zero  captured divisor was zero
//   overflow     true quotient does not fit in N bits
module h_u_seq_restoring_div8 #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [N:0]    r;          // partial remainder, one bit wider than the divisor
  logic [N-1:0]  q;          // quotient bits collected so far
  logic [N-1:0]  dvd_lo;     // dividend low half, consumed MSB first by shifting
  logic [N-1:0]  dvs;
  logic          dz_pend;
  logic          ov_pend;
  logic          accept;
  logic          flag_pend;
  logic          last_iter;

  logic [N:0]    r_sh;
  logic [N:0]    sub_b;
  logic [N:0]    sub_p;
  logic [N:0]    sub_g;
  logic [N+1:0]  sub_c;
  logic [N:0]    diff;
  logic          no_borrow;
  logic [N:0]    r_nx;
  logic [N-1:0]  q_nx;

  assign flag_pend = dz_pend | ov_pend;
  assign last_iter = (cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (flag_pend || last_iter) state_nx = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Trial subtraction r_sh - {0,dvs} as r_sh + ~{0,dvs} + 1 in
  // propagate/generate ripple form. A final carry of 1 means no borrow.
  // The top bit of r is always 0 while iterating, because the remainder
  // stays below the divisor after a restore.
  always_comb begin
    r_sh     = {r[N-1:0], dvd_lo[N-1]};
    sub_b    = ~{1'b0, dvs};
    sub_p    = '0;
    sub_g    = '0;
    diff     = '0;
    sub_c    = '0;
    sub_c[0] = 1'b1;
    for (int i = 0; i <= N; i++) begin
      sub_p[i]   = r_sh[i] ^ sub_b[i];
      sub_g[i]   = r_sh[i] & sub_b[i];
      sub_c[i+1] = sub_g[i] | (sub_p[i] & sub_c[i]);
      diff[i]    = sub_p[i] ^ sub_c[i];
    end
    no_borrow = sub_c[N+1];
    r_nx      = no_borrow ? diff : r_sh;
    q_nx      = N'({q, no_borrow});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      r           <= '0;
      q           <= '0;
      dvd_lo      <= '0;
      dvs         <= '0;
      dz_pend     <= 1'b0;
      ov_pend     <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      r       <= {1'b0, dividend[2*N-1:N]};
      q       <= '0;
      dvd_lo  <= dividend[N-1:0];
      dvs     <= divisor;
      dz_pend <= (divisor == '0);
      // Overflow is only checked for a nonzero divisor, so at most one
      // flag is set and div_by_zero wins.
      ov_pend <= (divisor != '0) && (dividend[2*N-1:N] >= divisor);
    end else if (state == RUN) begin
      if (flag_pend) begin
        quotient    <= '1;
        remainder   <= dvd_lo;
        div_by_zero <= dz_pend;
        overflow    <= ov_pend;
      end else begin
        r      <= r_nx;
        q      <= q_nx;
        dvd_lo <= dvd_lo << 1;
        cnt    <= cnt + CW'(1);
        if (last_iter) begin
          quotient    <= q_nx;
          remainder   <= r_nx[N-1:0];
          div_by_zero <= 1'b0;
          overflow    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_h_u_seq_restoring_div8.sv
// tb/tb_h_u_seq_restoring_div8.sv - directed and random bench for h_u_seq_restoring_div8
module tb_h_u_seq_restoring_div8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  h_u_seq_restoring_div8 #(.N(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one request and return the edge count up to done, counting the accepting edge as 1.
  task automatic do_op(input logic [15:0] dd, input logic [7:0] ds, output int edges);
    dividend = dd;
    divisor  = ds;
    start    = 1'b1;
    tick;
    start = 1'b0;
    edges = 1;
    while (done !== 1'b1 && edges < 30) begin
      tick;
      edges++;
    end
  endtask

  task automatic test_reset;
    rst      = 1'b1;
    start    = 1'b1;
    dividend = 16'h03E8;
    divisor  = 8'h07;
    tick;
    tick;
    rst   = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++;
    if ({quotient, remainder} !== 16'h0000) begin
      errors++; $display("FAIL reset_results: got q=%h r=%h expected 00 00", quotient, remainder);
    end
    checks++;
    if ({div_by_zero, overflow} !== 2'b00) begin
      errors++; $display("FAIL reset_flags: got dz=%b ov=%b expected 0 0", div_by_zero, overflow);
    end
    tick;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_hold: got busy=%b expected 0", busy); end
  endtask

  task automatic test_basic;
    logic [15:0] t_dd [6];
    logic [7:0]  t_ds [6];
    logic [7:0]  t_q  [6];
    logic [7:0]  t_r  [6];
    int          edges;
    t_dd = '{16'h03E8, 16'hFEFF, 16'h0064, 16'h00FF, 16'h0000, 16'h7FFF};
    t_ds = '{8'h07,    8'hFF,    8'h0A,    8'h01,    8'h01,    8'h80};
    t_q  = '{8'h8E,    8'hFF,    8'h0A,    8'hFF,    8'h00,    8'hFF};
    t_r  = '{8'h06,    8'hFE,    8'h00,    8'h00,    8'h00,    8'h7F};
    for (int i = 0; i < 6; i++) begin
      do_op(t_dd[i], t_ds[i], edges);
      checks++;
      if (edges !== 9) begin
        errors++; $display("FAIL basic_latency[%0d]: got %0d edges expected 9", i, edges);
      end
      checks++;
      if (quotient !== t_q[i] || remainder !== t_r[i]) begin
        errors++;
        $display("FAIL basic_result[%0d]: got q=%h r=%h expected q=%h r=%h",
                 i, quotient, remainder, t_q[i], t_r[i]);
      end
      checks++;
      if ({div_by_zero, overflow} !== 2'b00) begin
        errors++; $display("FAIL basic_flags[%0d]: got dz=%b ov=%b expected 0 0", i, div_by_zero, overflow);
      end
      tick;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL basic_pulse[%0d]: got done=%b busy=%b expected 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_div_by_zero;
    logic [15:0] t_dd [2];
    logic [7:0]  t_r  [2];
    int          edges;
    t_dd = '{16'h1234, 16'h0000};
    t_r  = '{8'h34,    8'h00};
    for (int i = 0; i < 2; i++) begin
      do_op(t_dd[i], 8'h00, edges);
      checks++;
      if (edges !== 2) begin
        errors++; $display("FAIL dz_latency[%0d]: got %0d edges expected 2", i, edges);
      end
      checks++;
      if (quotient !== 8'hFF || remainder !== t_r[i] || div_by_zero !== 1'b1 || overflow !== 1'b0) begin
        errors++;
        $display("FAIL dz_result[%0d]: got q=%h r=%h dz=%b ov=%b expected q=ff r=%h dz=1 ov=0",
                 i, quotient, remainder, div_by_zero, overflow, t_r[i]);
      end
    end
  endtask

  task automatic test_overflow;
    logic [15:0] t_dd [3];
    logic [7:0]  t_ds [3];
    logic [7:0]  t_r  [3];
    int          edges;
    t_dd = '{16'h0800, 16'hFF00, 16'h01AB};
    t_ds = '{8'h08,    8'hFF,    8'h01};
    t_r  = '{8'h00,    8'h00,    8'hAB};
    for (int i = 0; i < 3; i++) begin
      do_op(t_dd[i], t_ds[i], edges);
      checks++;
      if (edges !== 2) begin
        errors++; $display("FAIL ov_latency[%0d]: got %0d edges expected 2", i, edges);
      end
      checks++;
      if (quotient !== 8'hFF || remainder !== t_r[i] || div_by_zero !== 1'b0 || overflow !== 1'b1) begin
        errors++;
        $display("FAIL ov_result[%0d]: got q=%h r=%h dz=%b ov=%b expected q=ff r=%h dz=0 ov=1",
                 i, quotient, remainder, div_by_zero, overflow, t_r[i]);
      end
    end
  endtask

  task automatic test_ignore_busy;
    int edges;
    dividend = 16'h03E8;
    divisor  = 8'h07;
    start    = 1'b1;
    tick;
    start = 1'b0;
    edges = 1;
    tick; tick;
    edges += 2;
    dividend = 16'h0800;
    divisor  = 8'h00;
    start    = 1'b1;
    tick;
    edges++;
    start = 1'b0;
    while (done !== 1'b1 && edges < 30) begin
      tick;
      edges++;
    end
    checks++;
    if (edges !== 9) begin errors++; $display("FAIL busy_latency: got %0d edges expected 9", edges); end
    checks++;
    if (quotient !== 8'h8E || remainder !== 8'h06 || {div_by_zero, overflow} !== 2'b00) begin
      errors++;
      $display("FAIL busy_result: got q=%h r=%h dz=%b ov=%b expected q=8e r=06 dz=0 ov=0",
               quotient, remainder, div_by_zero, overflow);
    end
    tick;
    tick;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL busy_not_queued: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_abort;
    int edges;
    bit seen_done;
    dividend = 16'hFEFF;
    divisor  = 8'hFF;
    start    = 1'b1;
    tick;
    start = 1'b0;
    tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_ctrl: got busy=%b done=%b expected 0 0", busy, done);
    end
    checks++;
    if ({quotient, remainder, div_by_zero, overflow} !== 18'h0) begin
      errors++;
      $display("FAIL abort_outputs: got q=%h r=%h dz=%b ov=%b expected all 0",
               quotient, remainder, div_by_zero, overflow);
    end
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got activity=1 expected 0"); end
    do_op(16'h03E8, 8'h07, edges);
    checks++;
    if (edges !== 9 || quotient !== 8'h8E || remainder !== 8'h06) begin
      errors++;
      $display("FAIL abort_recover: got edges=%0d q=%h r=%h expected 9 8e 06", edges, quotient, remainder);
    end
  endtask

  task automatic test_back_to_back;
    int edges;
    dividend = 16'h03E8;
    divisor  = 8'h07;
    start    = 1'b1;
    tick;
    edges = 1;
    while (done !== 1'b1 && edges < 30) begin
      tick;
      edges++;
    end
    checks++;
    if (edges !== 9 || quotient !== 8'h8E || remainder !== 8'h06) begin
      errors++;
      $display("FAIL b2b_first: got edges=%0d q=%h r=%h expected 9 8e 06", edges, quotient, remainder);
    end
    dividend = 16'hFEFF;
    divisor  = 8'hFF;
    tick;
    edges = 1;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_no_idle: got busy=%b done=%b expected 1 0", busy, done);
    end
    checks++;
    if (quotient !== 8'h8E || remainder !== 8'h06) begin
      errors++; $display("FAIL b2b_hold: got q=%h r=%h expected 8e 06", quotient, remainder);
    end
    start = 1'b0;
    while (done !== 1'b1 && edges < 30) begin
      tick;
      edges++;
    end
    checks++;
    if (edges !== 9 || quotient !== 8'hFE + 8'h01 || remainder !== 8'hFE || overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: got edges=%0d q=%h r=%h ov=%b expected 9 ff fe 0",
               edges, quotient, remainder, overflow);
    end
  endtask

  task automatic test_random;
    logic [15:0] dd;
    logic [7:0]  ds;
    logic [7:0]  eq;
    logic [7:0]  er;
    logic        edz;
    logic        eov;
    int          eedges;
    int          edges;
    for (int n = 0; n < 10000; n++) begin
      dd = 16'($urandom);
      ds = 8'($urandom);
      if (ds == 8'h00) begin
        edz = 1'b1; eov = 1'b0; eq = 8'hFF; er = dd[7:0]; eedges = 2;
      end else if (dd[15:8] >= ds) begin
        edz = 1'b0; eov = 1'b1; eq = 8'hFF; er = dd[7:0]; eedges = 2;
      end else begin
        edz = 1'b0; eov = 1'b0; eq = 8'(dd / ds); er = 8'(dd % ds); eedges = 9;
      end
      do_op(dd, ds, edges);
      checks++;
      if ({div_by_zero, overflow, quotient, remainder} !== {edz, eov, eq, er} || edges !== eedges ||
          (!edz && !eov && ((32'(quotient) * 32'(ds) + 32'(remainder)) !== 32'(dd) || remainder >= ds))) begin
        errors++;
        $display("FAIL random[%0d] %h/%h: got q=%h r=%h dz=%b ov=%b edges=%0d expected q=%h r=%h dz=%b ov=%b edges=%0d",
                 n, dd, ds, quotient, remainder, div_by_zero, overflow, edges, eq, er, edz, eov, eedges);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    test_reset;
    test_basic;
    test_div_by_zero;
    test_overflow;
    test_ignore_busy;
    test_abort;
    test_back_to_back;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
